// File: rtl/raw2rgb_quad.sv
// Nearest-neighbour 2x2 Bayer quad demosaic for a 2-pixel-per-clock stream; both output pixels share one RGB.
// Latency 2 cycles for data/valid/vsync/eol; 1 word per cycle, no backpressure (i_valid gaps pass straight through).
module raw2rgb_quad #(
    parameter int          P_DEPTH     = 10,
    parameter int          PW          = P_DEPTH * 2,
    parameter int          FRAME_WIDTH = 640,
    parameter logic [31:0] BAYER       = "RGGB"
) (
    input  logic                 i_pclk,
    input  logic                 i_arst,
    input  logic                 i_vsync,
    input  logic                 i_valid,
    input  logic [PW-1:0]        i_p_cur,
    input  logic [PW-1:0]        i_p_prev,
    output logic                 o_vsync,
    output logic                 o_valid,
    output logic [6*P_DEPTH-1:0] o_rgb,
    output logic                 o_eol
);

    localparam int WPL = FRAME_WIDTH / 2;
    localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(WPL - 1);
    localparam int SEL = (BAYER == "RGGB") ? 0 :
                         (BAYER == "GRBG") ? 1 :
                         (BAYER == "GBRG") ? 2 :
                         (BAYER == "BGGR") ? 3 : -1;

    generate
        if (SEL < 0) begin : g_bad_bayer
            $error("raw2rgb_quad: unsupported BAYER pattern");
        end
        if ((FRAME_WIDTH % 2) != 0) begin : g_bad_width
            $error("raw2rgb_quad: FRAME_WIDTH must be even");
        end
    endgenerate

    logic [CW-1:0]      r_col;
    logic               r_odd;
    logic               r_first;

    logic               r_s1_vsync;
    logic               r_s1_valid;
    logic               r_s1_eol;
    logic               r_s1_first;
    logic [P_DEPTH-1:0] r_s1_r;
    logic [P_DEPTH-1:0] r_s1_b;
    logic [P_DEPTH-1:0] r_s1_ga;
    logic [P_DEPTH-1:0] r_s1_gb;

    logic               w_fall;
    logic [CW-1:0]      w_col;
    logic               w_odd;
    logic               w_first;
    logic               w_last;
    logic [PW-1:0]      w_top;
    logic [PW-1:0]      w_bot;
    logic [P_DEPTH-1:0] w_top_e;
    logic [P_DEPTH-1:0] w_top_o;
    logic [P_DEPTH-1:0] w_bot_e;
    logic [P_DEPTH-1:0] w_bot_o;
    logic [P_DEPTH-1:0] w_r;
    logic [P_DEPTH-1:0] w_b;
    logic [P_DEPTH-1:0] w_ga;
    logic [P_DEPTH-1:0] w_gb;
    logic [P_DEPTH:0]   w_gsum;
    logic [P_DEPTH-1:0] w_g;

    // A falling vsync restarts the frame in the same cycle, so a coincident word is column 0 of line 0.
    assign w_fall  = r_s1_vsync & ~i_vsync;
    assign w_col   = w_fall ? '0 : r_col;
    assign w_odd   = w_fall ? 1'b0 : r_odd;
    assign w_first = w_fall ? 1'b1 : r_first;
    assign w_last  = (w_col == LAST_COL);

    assign w_top   = w_odd ? i_p_prev : i_p_cur;
    assign w_bot   = w_odd ? i_p_cur  : i_p_prev;
    assign w_top_e = w_top[P_DEPTH-1:0];
    assign w_top_o = w_top[PW-1:P_DEPTH];
    assign w_bot_e = w_bot[P_DEPTH-1:0];
    assign w_bot_o = w_bot[PW-1:P_DEPTH];

    always_comb begin
        w_r  = w_top_e;
        w_b  = w_bot_o;
        w_ga = w_top_o;
        w_gb = w_bot_e;
        case (SEL)
            1: begin
                w_r  = w_top_o;
                w_b  = w_bot_e;
                w_ga = w_top_e;
                w_gb = w_bot_o;
            end
            2: begin
                w_b  = w_top_o;
                w_r  = w_bot_e;
                w_ga = w_top_e;
                w_gb = w_bot_o;
            end
            3: begin
                w_b  = w_top_e;
                w_r  = w_bot_o;
                w_ga = w_top_o;
                w_gb = w_bot_e;
            end
            default: begin
                w_r  = w_top_e;
                w_b  = w_bot_o;
                w_ga = w_top_o;
                w_gb = w_bot_e;
            end
        endcase
    end

    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            r_col   <= '0;
            r_odd   <= 1'b0;
            r_first <= 1'b1;
        end else if (i_valid) begin
            if (w_last) begin
                r_col   <= '0;
                r_odd   <= ~w_odd;
                r_first <= 1'b0;
            end else begin
                r_col   <= w_col + CW'(1);
                r_odd   <= w_odd;
                r_first <= w_first;
            end
        end else if (w_fall) begin
            r_col   <= '0;
            r_odd   <= 1'b0;
            r_first <= 1'b1;
        end
    end

    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            r_s1_vsync <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_first <= 1'b1;
            r_s1_r     <= '0;
            r_s1_b     <= '0;
            r_s1_ga    <= '0;
            r_s1_gb    <= '0;
        end else begin
            r_s1_vsync <= i_vsync;
            r_s1_valid <= i_valid;
            r_s1_eol   <= i_valid & w_last;
            r_s1_first <= w_first;
            r_s1_r     <= w_r;
            r_s1_b     <= w_b;
            r_s1_ga    <= w_ga;
            r_s1_gb    <= w_gb;
        end
    end

    // Green average keeps the carry bit, then drops the LSB (truncation, no rounding).
    assign w_gsum = {1'b0, r_s1_ga} + {1'b0, r_s1_gb};
    assign w_g    = w_gsum[P_DEPTH:1];

    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            o_vsync <= 1'b0;
            o_valid <= 1'b0;
            o_eol   <= 1'b0;
            o_rgb   <= '0;
        end else begin
            o_vsync <= r_s1_vsync;
            o_valid <= r_s1_valid;
            o_eol   <= r_s1_eol;
            o_rgb   <= r_s1_first ? '0 : {r_s1_r, w_g, r_s1_b, r_s1_r, w_g, r_s1_b};
        end
    end

endmodule

// File: doc/raw2rgb_quad.md
# raw2rgb_quad

Bayer-to-RGB converter for the 2-pixel-per-clock camera path. Consumes the current-line and previous-line pixel pairs produced by the line buffer, forms one 2x2 Bayer quad per valid word, and emits the same RGB value for both output pixels of that word (nearest-neighbour quad demosaic). Sits between the line buffer and the downscaler/framebuffer writer in the camera clock domain.

## Interface
- P_DEPTH, 10, bits per raw pixel and per output colour channel
- PW, P_DEPTH*2, input word width (2PPC: bits [P_DEPTH-1:0] even column, [PW-1:P_DEPTH] odd column)
- FRAME_WIDTH, 640, pixels per line (even); words per line = FRAME_WIDTH/2
- BAYER, "RGGB", sensor pattern: "RGGB", "GRBG", "GBRG" or "BGGR" (row 0 pair, then row 1 pair)

- i_pclk  in  1  pixel clock; sole clock
- i_arst  in  1  reset, asynchronous, active-high
- i_vsync  in  1  frame sync; frame starts on falling edge
- i_valid  in  1  word qualifier for i_p_cur/i_p_prev
- i_p_cur  in  PW  current-line pixel pair (line y)
- i_p_prev  in  PW  previous-line pixel pair, same column (line y-1)
- o_vsync  out  1  i_vsync delayed 2 cycles
- o_valid  out  1  i_valid delayed 2 cycles
- o_rgb  out  6*P_DEPTH  [3*P_DEPTH-1:0] even pixel {R,G,B} (R MSBs), [6*P_DEPTH-1:3*P_DEPTH] odd pixel, identical value
- o_eol  out  1  high with o_valid on the last word of each line

## Operation
- Word counter col (width clog2(FRAME_WIDTH/2)): +1 per i_valid; at FRAME_WIDTH/2-1 with i_valid wraps to 0, toggles line parity bit odd, clears first_line flag.
- Falling edge of i_vsync (registered i_vsync=1, current i_vsync=0): col<=0, odd<=0, first_line<=1. If i_valid is high that same cycle, the word is column 0 of line 0 of the new frame (col becomes 1 after it).
- Row orientation per word: line y odd (odd=1) -> top=i_p_prev, bot=i_p_cur; y even -> top=i_p_cur, bot=i_p_prev. top/bot then match pattern rows 0/1.
- Channel select (e=even column half, o=odd half):
  - RGGB: R=top.e, B=bot.o, G pair top.o/bot.e
  - GRBG: R=top.o, B=bot.e, G pair top.e/bot.o
  - GBRG: B=top.o, R=bot.e, G pair top.e/bot.o
  - BGGR: B=top.e, R=bot.o, G pair top.o/bot.e
- G = (Ga + Gb) >> 1, computed at P_DEPTH+1 bits, truncated (no rounding). R, B passed unchanged.
- first_line words (line 0, no valid previous line): o_rgb forced to 0, o_valid still asserted.
- Unsupported BAYER string: elaboration error.
- Reset: all pipeline registers, col, odd cleared, first_line=1; o_vsync, o_valid, o_eol, o_rgb = 0 while i_arst high and until data propagates.
- Reset asserted mid-line: state cleared asynchronously; after release, next word treated as column 0 of line 0.

## Timing
- Stage 1 (cycle n+1): register inputs, row orientation, channel select, first_line/eol tags. Stage 2 (n+2): G average, zero-force, drive outputs.
- Latency 2 cycles input to output for data, valid, vsync and eol alike; throughput 1 word/cycle, no backpressure.
- i_valid gaps (low cycles) inside a line: counter holds, no output; pipeline advances regardless (o_valid=0 in gap slots).
- o_eol is combinational-free: registered alongside o_valid, never high when o_valid=0.

## Test plan
- Reset: hold i_arst 3 cycles with random inputs -> all outputs 0; release, first output word has o_rgb=0 (line 0).
- RGGB, P_DEPTH=10, FRAME_WIDTH=8: line 0 (4 words) then line 1 word prev={G=0x100,R=0x200}, cur={B=0x040,G=0x180} -> 2 cycles later o_rgb each pixel R=0x200, G=0x140, B=0x040.
- Line 2 (even) with cur={G=0x100,R=0x200}, prev={B=0x040,G=0x180} -> same RGB; confirms row swap; o_eol on 4th word of every line only.
- G truncation: greens 0x3FF and 0x3FE -> G=0x3FE; greens 0x001/0x000 -> G=0x000.
- Each of GRBG, GBRG, BGGR with a distinct-value quad -> R/B/G taken from the positions listed above.
- vsync falling edge mid-line with simultaneous i_valid -> that word outputs 0 (line 0), col restarts; i_valid gaps of 1-3 cycles -> o_valid gaps identical, delayed by 2 cycles.
